// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin arbiter and sequencer in front of a single fpu adder.
//
// Two requesters each offer an operand pair over a valid/ready handshake. The
// winner's operands are driven to the fpu and held for SETTLE_CYCLES cycles.
// The fpu result and status are then captured and returned on that
// requester's response channel, and held there until the requester consumes
// them.
//
// Ports
//   clock100KHz                       system clock, rising edge
//   reset                             asynchronous, active-low
//   req0_valid/ready/a/b              requester 0 operand channel
//   req1_valid/ready/a/b              requester 1 operand channel
//   rsp0_valid/ready/data/status      requester 0 result channel
//   rsp1_valid/ready/data/status      requester 1 result channel
//   fpu_op_A, fpu_op_B                operands to the fpu (registered)
//   fpu_data_in, fpu_status_in        result and status from the fpu
//   busy                              high whenever a transaction is in flight
//
// Optional build macro FPU_ARB_ERR_CNT_EN adds the ovf_count and unf_count
// outputs. These are saturating counters of captured overflow and underflow
// statuses.

module fpu_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 128,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic [3:0]  rsp0_status,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic [3:0]  rsp1_status,
  output logic [31:0] fpu_op_A,
  output logic [31:0] fpu_op_B,
  input  logic [31:0] fpu_data_in,
  input  logic [3:0]  fpu_status_in,
`ifdef FPU_ARB_ERR_CNT_EN
  output logic [7:0]  ovf_count,
  output logic [7:0]  unf_count,
`endif
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StSettle,
    StCapture,
    StRespond
  } state_e;

  state_e             state_q, state_d;
  logic               last_grant_q;
  logic               grant_id_q;
  logic [31:0]        op_a_q, op_b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               grant0, grant1;
  logic               rsp_fire;

  // On a tie, the requester that was not served last wins.
  assign grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

  assign rsp_fire = grant_id_q ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

  assign busy = (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      StIdle: begin
        // Ready is combinational on valid so the accept costs no extra cycle.
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) state_d = StIssue;
      end
      StIssue:   state_d = StSettle;
      StSettle:  if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = StCapture;
      StCapture: state_d = StRespond;
      StRespond: if (rsp_fire) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      cnt_q        <= '0;
      fpu_op_A     <= '0;
      fpu_op_B     <= '0;
      rsp0_valid   <= 1'b0;
      rsp0_data    <= '0;
      rsp0_status  <= '0;
      rsp1_valid   <= 1'b0;
      rsp1_data    <= '0;
      rsp1_status  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req0_ready || req1_ready) begin
            op_a_q       <= req1_ready ? req1_a : req0_a;
            op_b_q       <= req1_ready ? req1_b : req0_b;
            grant_id_q   <= req1_ready;
            last_grant_q <= req1_ready;
          end
        end
        StIssue: begin
          fpu_op_A <= op_a_q;
          fpu_op_B <= op_b_q;
          cnt_q    <= '0;
        end
        StSettle: begin
          cnt_q <= cnt_q + 1'b1;
        end
        StCapture: begin
          // Only the granted channel is written; the other one stays untouched.
          if (grant_id_q) begin
            rsp1_data   <= fpu_data_in;
            rsp1_status <= fpu_status_in;
            rsp1_valid  <= 1'b1;
          end else begin
            rsp0_data   <= fpu_data_in;
            rsp0_status <= fpu_status_in;
            rsp0_valid  <= 1'b1;
          end
        end
        StRespond: begin
          if (rsp_fire) begin
            if (grant_id_q) rsp1_valid <= 1'b0;
            else            rsp0_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FPU_ARB_ERR_CNT_EN
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      ovf_count <= '0;
      unf_count <= '0;
    end else if (state_q == StCapture) begin
      if (fpu_status_in == 4'b0100 && ovf_count != 8'hFF) ovf_count <= ovf_count + 1'b1;
      if (fpu_status_in == 4'b1000 && unf_count != 8'hFF) unf_count <= unf_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// Testbench for fpu_arbiter.
//
// A stand-in fpu computes data = A + B. Its one-hot status is selected by the
// two low bits of the sum: 0 gives 0001, 1 gives 0010, 2 gives 0100 and
// 3 gives 1000.
//
// A transaction-level model tracks each accepted request by its age in cycles
// and predicts every output on each falling edge. Directed checks pin the
// latency, the grant order, back-pressure and reset abort with literal values.

module tb_fpu_arbiter;

  localparam int S = 128;

  logic        clock100KHz = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_data, rsp1_data;
  logic [3:0]  rsp0_status, rsp1_status;
  logic [31:0] fpu_op_A, fpu_op_B, fpu_data_in;
  logic [3:0]  fpu_status_in;
  logic        busy;
`ifdef FPU_ARB_ERR_CNT_EN
  logic [7:0]  ovf_count, unf_count;
`endif

  int total = 0;
  int bad = 0;

  always #5 clock100KHz = ~clock100KHz;

  function automatic logic [35:0] fpu_fn(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    return {4'b0001 << s[1:0], s};
  endfunction

  assign {fpu_status_in, fpu_data_in} = fpu_fn(fpu_op_A, fpu_op_B);

  fpu_arbiter dut (
    .clock100KHz  (clock100KHz),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .rsp0_valid   (rsp0_valid),
    .rsp0_ready   (rsp0_ready),
    .rsp0_data    (rsp0_data),
    .rsp0_status  (rsp0_status),
    .rsp1_valid   (rsp1_valid),
    .rsp1_ready   (rsp1_ready),
    .rsp1_data    (rsp1_data),
    .rsp1_status  (rsp1_status),
    .fpu_op_A     (fpu_op_A),
    .fpu_op_B     (fpu_op_B),
    .fpu_data_in  (fpu_data_in),
    .fpu_status_in(fpu_status_in),
`ifdef FPU_ARB_ERR_CNT_EN
    .ovf_count    (ovf_count),
    .unf_count    (unf_count),
`endif
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic        m_busy, m_gid, m_last;
  int          m_age;
  logic [31:0] m_pa, m_pb, m_opa, m_opb;
  logic [1:0]  m_rv;
  logic [31:0] m_rd [2];
  logic [3:0]  m_rs [2];
  int          m_ovf, m_unf;
  logic        m_g0, m_g1, m_rdy_g;

  always_comb begin
    m_g0    = !m_busy && req0_valid && (!req1_valid || m_last);
    m_g1    = !m_busy && req1_valid && (!req0_valid || !m_last);
    m_rdy_g = m_gid ? rsp1_ready : rsp0_ready;
  end

  always @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_gid <= 1'b0; m_last <= 1'b1; m_age <= 0;
      m_pa <= '0; m_pb <= '0; m_opa <= '0; m_opb <= '0; m_rv <= '0;
      m_rd[0] <= '0; m_rd[1] <= '0; m_rs[0] <= '0; m_rs[1] <= '0;
      m_ovf <= 0; m_unf <= 0;
    end else if (!m_busy) begin
      if (m_g0 || m_g1) begin
        m_busy <= 1'b1; m_age <= 0; m_gid <= m_g1; m_last <= m_g1;
        m_pa <= m_g1 ? req1_a : req0_a;
        m_pb <= m_g1 ? req1_b : req0_b;
      end
    end else begin
      m_age <= m_age + 1;
      // One cycle after accept the operands reach the fpu; S+2 after accept
      // the result is captured and presented.
      if (m_age + 1 == 1) begin
        m_opa <= m_pa; m_opb <= m_pb;
      end
      if (m_age + 1 == S + 2) begin
        m_rv[m_gid] <= 1'b1;
        {m_rs[m_gid], m_rd[m_gid]} <= fpu_fn(m_opa, m_opb);
        if (fpu_fn(m_opa, m_opb) >> 32 == 36'h4 && m_ovf < 255) m_ovf <= m_ovf + 1;
        if (fpu_fn(m_opa, m_opb) >> 32 == 36'h8 && m_unf < 255) m_unf <= m_unf + 1;
      end else if (m_age + 1 > S + 2 && m_rv[m_gid] && m_rdy_g) begin
        m_rv[m_gid] <= 1'b0;
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clock100KHz) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("req0_ready", 32'(req0_ready), 32'(m_g0));
    check("req1_ready", 32'(req1_ready), 32'(m_g1));
    check("fpu_op_A", fpu_op_A, m_opa);
    check("fpu_op_B", fpu_op_B, m_opb);
    check("rsp0_valid", 32'(rsp0_valid), 32'(m_rv[0]));
    check("rsp0_data", rsp0_data, m_rd[0]);
    check("rsp0_status", 32'(rsp0_status), 32'(m_rs[0]));
    check("rsp1_valid", 32'(rsp1_valid), 32'(m_rv[1]));
    check("rsp1_data", rsp1_data, m_rd[1]);
    check("rsp1_status", 32'(rsp1_status), 32'(m_rs[1]));
`ifdef FPU_ARB_ERR_CNT_EN
    check("ovf_count", 32'(ovf_count), 32'(m_ovf));
    check("unf_count", 32'(unf_count), 32'(m_unf));
`endif
  end

  // ---------------- directed stimulus ----------------
  int r0_pulses = 0;
  always @(negedge clock100KHz) if (req0_ready) r0_pulses++;

  function automatic logic sig(input int sel);
    case (sel)
      0:       return req0_ready;
      1:       return req1_ready;
      2:       return rsp0_valid;
      3:       return rsp1_valid;
      4:       return req0_ready || req1_ready;
      default: return !busy;
    endcase
  endfunction

  // Waits on falling edges until the selected condition holds; n = samples taken.
  task automatic wait_hi(input int sel, input int limit, output int n);
    for (int i = 1; i <= limit; i++) begin
      @(negedge clock100KHz);
      if (sig(sel)) begin
        n = i;
        return;
      end
    end
    n = -1;
    total++;
    bad++;
    $display("FAIL wait_timeout sel=%0d got none want within %0d cycles", sel, limit);
  endtask

  task automatic tick();
    @(posedge clock100KHz);
    #1;
  endtask

  initial begin
    int n, p0, r0hits, r1hits;
    logic [1:0] seq [4];

    repeat (3) @(posedge clock100KHz);
    #1 reset = 1'b1;
    @(negedge clock100KHz);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_fpu_op_A", fpu_op_A, 32'd0);

    // Single request and latency.
    tick();
    req0_a = 32'h0400_0000; req0_b = 32'h0400_0000; req0_valid = 1'b1;
    p0 = r0_pulses;
    wait_hi(0, 5, n);
    check("t1_accept_now", 32'(n), 32'd1);
    tick();
    req0_valid = 1'b0;
    wait_hi(2, 200, n);
    // Valid rises 130 edges after the accept edge, seen on the 131st sample.
    check("t1_latency", 32'(n), 32'd131);
    check("t1_data", rsp0_data, 32'h0800_0000);
    check("t1_status", 32'(rsp0_status), 32'b0001);
    check("t1_ready_pulses", 32'(r0_pulses - p0), 32'd1);
    tick(); rsp0_ready = 1'b1;
    tick(); rsp0_ready = 1'b0;
    @(negedge clock100KHz);
    check("t1_rsp_cleared", 32'(rsp0_valid), 32'd0);

    // Both requesters held valid after reset: alternating grants.
    tick(); reset = 1'b0;
    tick(); reset = 1'b1;
    req0_a = 32'd1;    req0_b = 32'd2;
    req1_a = 32'h10;   req1_b = 32'h20;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_hi(4, 300, n);
      seq[k] = {1'b0, req1_ready};
      tick();
      if (seq[k][0]) req1_a = req1_a + 32'd1;
      else           req0_a = req0_a + 32'd1;
      if (k == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
    end
    check("t2_grant0", 32'(seq[0]), 32'd0);
    check("t2_grant1", 32'(seq[1]), 32'd1);
    check("t2_grant2", 32'(seq[2]), 32'd0);
    check("t2_grant3", 32'(seq[3]), 32'd1);
    wait_hi(5, 300, n);

    // Back-pressure on requester 1 while requester 0 waits.
    tick();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req1_a = 32'h100; req1_b = 32'h200; req1_valid = 1'b1;
    wait_hi(1, 5, n);
    tick(); req1_valid = 1'b0;
    wait_hi(3, 200, n);
    tick();
    req0_a = 32'd5; req0_b = 32'd6; req0_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock100KHz);
      check("t3_rsp1_valid", 32'(rsp1_valid), 32'd1);
      check("t3_rsp1_data", rsp1_data, 32'h300);
      check("t3_rsp1_status", 32'(rsp1_status), 32'b0001);
      check("t3_busy", 32'(busy), 32'd1);
      check("t3_req0_blocked", 32'(req0_ready), 32'd0);
    end
    tick(); rsp1_ready = 1'b1;
    tick(); rsp1_ready = 1'b0;
    @(negedge clock100KHz);
    check("t3_req0_accept", 32'(req0_ready), 32'd1);
    tick(); req0_valid = 1'b0; rsp0_ready = 1'b1;
    wait_hi(2, 200, n);
    check("t3_rsp0_data", rsp0_data, 32'hB);
    check("t3_rsp0_status", 32'(rsp0_status), 32'b1000);
    wait_hi(5, 10, n);

    // Reset during SETTLE aborts the transaction.
    tick();
    rsp0_ready = 1'b1;
    req0_a = 32'd7; req0_b = 32'd8; req0_valid = 1'b1;
    wait_hi(0, 5, n);
    tick(); req0_valid = 1'b0;
    repeat (20) @(posedge clock100KHz);
    #1 reset = 1'b0;
    @(negedge clock100KHz);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_op_A", fpu_op_A, 32'd0);
    check("t4_op_B", fpu_op_B, 32'd0);
    check("t4_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("t4_rsp1_data", rsp1_data, 32'd0);
    tick(); reset = 1'b1;
    req1_a = 32'h1000; req1_b = 32'h2000; req1_valid = 1'b1; rsp1_ready = 1'b1;
    wait_hi(1, 5, n);
    check("t4_req1_accept_now", 32'(n), 32'd1);
    tick(); req1_valid = 1'b0;
    r0hits = 0; r1hits = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock100KHz);
      if (rsp0_valid) r0hits++;
      if (rsp1_valid) begin
        r1hits++;
        check("t4_rsp1_data", rsp1_data, 32'h3000);
      end
    end
    check("t4_no_rsp0", 32'(r0hits), 32'd0);
    check("t4_rsp1_seen", 32'(r1hits != 0), 32'd1);

`ifdef FPU_ARB_ERR_CNT_EN
    // 1 + 1 = 2 selects overflow status on the stand-in fpu.
    tick();
    rsp0_ready = 1'b1;
    req0_a = 32'd1; req0_b = 32'd1;
    for (int k = 0; k < 260; k++) begin
      req0_valid = 1'b1;
      wait_hi(0, 10, n);
      tick(); req0_valid = 1'b0;
      wait_hi(2, 200, n);
      if (k == 0) begin
        check("t5_status", 32'(rsp0_status), 32'b0100);
        @(negedge clock100KHz);
        check("t5_ovf_first", 32'(ovf_count), 32'd1);
      end
      wait_hi(5, 10, n);
      tick();
    end
    check("t5_ovf_sat", 32'(ovf_count), 32'd255);
    check("t5_unf", 32'(unf_count), 32'd0);
`endif

    repeat (2) @(posedge clock100KHz);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
